// File: rtl/output_demux_six_ports_if.sv
// AXI-Stream bundle used by the six-port output demux (one slave side, six master sides).
interface output_demux_six_ports_if #(
   parameter int TDATA_W = 256,
   parameter int TUSER_W = 128
) ();
   logic [TDATA_W-1:0]   tdata;
   logic [TDATA_W/8-1:0] tkeep;
   logic [TUSER_W-1:0]   tuser;
   logic                 tvalid;
   logic                 tlast;
   logic                 tready;

   modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
   modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/output_demux_six_ports.sv
// Routes each AXI-Stream packet to the one-hot/multicast set of six master ports named in tuser.
//
// state | meaning
// IDLE  | awaiting the first beat of a packet; mask comes from the live tuser
// FWD   | mid-packet, forwarding beats using the mask latched at the first beat
// DROP  | mid-packet, consuming and discarding beats of a packet with no destination
module output_demux_six_ports #(
   parameter int C_S_AXIS_DATA_WIDTH  = 256,
   parameter int C_M_AXIS_DATA_WIDTH  = 256,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,
   parameter int C_M_AXIS_TUSER_WIDTH = 128,
   parameter int DST_PORT_POS         = 24
) (
   input  logic axis_aclk,
   input  logic axis_reset,
   output_demux_six_ports_if.slave  s_axis,
   output_demux_six_ports_if.master m_axis_0,
   output_demux_six_ports_if.master m_axis_1,
   output_demux_six_ports_if.master m_axis_2,
   output_demux_six_ports_if.master m_axis_3,
   output_demux_six_ports_if.master m_axis_4,
   output_demux_six_ports_if.master m_axis_5,
   output logic pkt_fwd,
   output logic pkt_drop
);

   if (C_M_AXIS_DATA_WIDTH != C_S_AXIS_DATA_WIDTH) begin : g_bad_data_w
      $error("output_demux_six_ports: master and slave tdata widths differ");
   end
   if (C_M_AXIS_TUSER_WIDTH != C_S_AXIS_TUSER_WIDTH) begin : g_bad_tuser_w
      $error("output_demux_six_ports: master and slave tuser widths differ");
   end

   typedef enum logic [1:0] {S_IDLE, S_FWD, S_DROP} state_t;

   state_t     state_q, state_d;
   logic [5:0] mask_q, mask_d;
   logic [5:0] sent_q, sent_d;
   logic       pkt_fwd_q, pkt_fwd_d;
   logic       pkt_drop_q, pkt_drop_d;

   logic [5:0] dst, act_mask, m_tvalid, m_tready, port_ok;
   logic       dropping, s_tready, s_hs;

   assign m_tready = {m_axis_5.tready, m_axis_4.tready, m_axis_3.tready,
                      m_axis_2.tready, m_axis_1.tready, m_axis_0.tready};

   // Handshake datapath; sent_q remembers ports that already took the current beat.
   always_comb begin
      dst      = s_axis.tuser[DST_PORT_POS +: 6];
      act_mask = (state_q == S_IDLE) ? dst : mask_q;
      dropping = (state_q == S_DROP) || ((state_q == S_IDLE) && (dst == 6'd0));
      m_tvalid = (s_axis.tvalid && !dropping && !axis_reset) ? (act_mask & ~sent_q) : 6'd0;
      port_ok  = ~act_mask | sent_q | m_tready;
      s_tready = !axis_reset && (dropping || (&port_ok));
      s_hs     = s_axis.tvalid && s_tready;
      sent_d   = s_hs ? 6'd0 : (sent_q | (m_tvalid & m_tready));
   end

   always_comb begin
      state_d    = state_q;
      mask_d     = mask_q;
      pkt_fwd_d  = 1'b0;
      pkt_drop_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (s_hs) begin
               if (dst != 6'd0) begin
                  pkt_fwd_d = 1'b1;
                  if (!s_axis.tlast) begin
                     mask_d  = dst;
                     state_d = S_FWD;
                  end
               end else begin
                  pkt_drop_d = 1'b1;
                  if (!s_axis.tlast) state_d = S_DROP;
               end
            end
         end
         S_FWD, S_DROP: begin
            if (s_hs && s_axis.tlast) begin
               mask_d  = 6'd0;
               state_d = S_IDLE;
            end
         end
         default: begin
            mask_d  = 6'd0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge axis_aclk) begin
      if (axis_reset) begin
         state_q    <= S_IDLE;
         mask_q     <= 6'd0;
         sent_q     <= 6'd0;
         pkt_fwd_q  <= 1'b0;
         pkt_drop_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         mask_q     <= mask_d;
         sent_q     <= sent_d;
         pkt_fwd_q  <= pkt_fwd_d;
         pkt_drop_q <= pkt_drop_d;
      end
   end

   // Pulses are masked during reset so a pulse earned on the reset cycle never escapes.
   assign pkt_fwd       = pkt_fwd_q  && !axis_reset;
   assign pkt_drop      = pkt_drop_q && !axis_reset;
   assign s_axis.tready = s_tready;

   assign m_axis_0.tdata = s_axis.tdata;
   assign m_axis_0.tkeep = s_axis.tkeep;
   assign m_axis_0.tuser = s_axis.tuser;
   assign m_axis_0.tlast = s_axis.tlast;
   assign m_axis_0.tvalid = m_tvalid[0];

   assign m_axis_1.tdata = s_axis.tdata;
   assign m_axis_1.tkeep = s_axis.tkeep;
   assign m_axis_1.tuser = s_axis.tuser;
   assign m_axis_1.tlast = s_axis.tlast;
   assign m_axis_1.tvalid = m_tvalid[1];

   assign m_axis_2.tdata = s_axis.tdata;
   assign m_axis_2.tkeep = s_axis.tkeep;
   assign m_axis_2.tuser = s_axis.tuser;
   assign m_axis_2.tlast = s_axis.tlast;
   assign m_axis_2.tvalid = m_tvalid[2];

   assign m_axis_3.tdata = s_axis.tdata;
   assign m_axis_3.tkeep = s_axis.tkeep;
   assign m_axis_3.tuser = s_axis.tuser;
   assign m_axis_3.tlast = s_axis.tlast;
   assign m_axis_3.tvalid = m_tvalid[3];

   assign m_axis_4.tdata = s_axis.tdata;
   assign m_axis_4.tkeep = s_axis.tkeep;
   assign m_axis_4.tuser = s_axis.tuser;
   assign m_axis_4.tlast = s_axis.tlast;
   assign m_axis_4.tvalid = m_tvalid[4];

   assign m_axis_5.tdata = s_axis.tdata;
   assign m_axis_5.tkeep = s_axis.tkeep;
   assign m_axis_5.tuser = s_axis.tuser;
   assign m_axis_5.tlast = s_axis.tlast;
   assign m_axis_5.tvalid = m_tvalid[5];

endmodule

// File: doc/output_demux_six_ports.md
OUTPUT_DEMUX_SIX_PORTS -- requirements
Module: output_demux_six_ports

Interface
REQ-001 SHALL have parameter C_S_AXIS_DATA_WIDTH, default 256, slave tdata width.
REQ-002 SHALL have parameter C_M_AXIS_DATA_WIDTH, default 256, master tdata width; SHALL equal C_S_AXIS_DATA_WIDTH.
REQ-003 SHALL have parameter C_S_AXIS_TUSER_WIDTH, default 128, slave tuser width.
REQ-004 SHALL have parameter C_M_AXIS_TUSER_WIDTH, default 128, master tuser width; SHALL equal C_S_AXIS_TUSER_WIDTH.
REQ-005 SHALL have parameter DST_PORT_POS, default 24, LSB of the 6-bit one-hot destination field in tuser.
REQ-006 SHALL have one clock and a synchronous, active-high reset.
REQ-007 axis_aclk  input  1  clock; all logic on rising edge.
REQ-008 axis_reset  input  1  synchronous active-high reset.
REQ-009 s_axis_tdata/tkeep/tuser  input  256/32/128  slave data, byte enables, metadata.
REQ-010 s_axis_tvalid, s_axis_tlast  input  1 each; s_axis_tready  output  1.
REQ-011 m_axis_N_tdata/tkeep/tuser  output  256/32/128  for N=0..5, master payload.
REQ-012 m_axis_N_tvalid, m_axis_N_tlast  output  1 each; m_axis_N_tready  input  1; N=0..5.
REQ-013 pkt_fwd  output  1  registered one-cycle pulse per forwarded packet.
REQ-014 pkt_drop  output  1  registered one-cycle pulse per dropped packet.

Function
REQ-015 Destination mask dst = s_axis_tuser[DST_PORT_POS+5:DST_PORT_POS]; bit N selects port N; multiple bits = multicast.
REQ-016 tdata, tkeep, tuser, tlast SHALL fan out combinationally to all six master ports; no added latency.
REQ-017 FSM states: IDLE (awaiting first beat), FWD (mid-packet, forwarding), DROP (mid-packet, discarding).
REQ-018 In IDLE the active mask SHALL be dst from the current beat; in FWD/DROP the mask latched at the first beat SHALL be used.
REQ-019 Per-port sent[N] register SHALL record ports that already accepted the current beat.
REQ-020 m_axis_N_tvalid = s_axis_tvalid & mask[N] & ~sent[N] & ~dropping; SHALL not depend on any m_axis_N_tready.
REQ-021 s_axis_tready = AND over N of (~mask[N] | sent[N] | m_axis_N_tready) when forwarding; = 1 when dropping.
REQ-022 On a port handshake without slave handshake, sent[N] SHALL set; on slave handshake all sent bits SHALL clear.
REQ-023 IDLE: first-beat handshake with dst!=0 -> latch mask, pkt_fwd=1 next cycle, go FWD unless tlast (then stay IDLE).
REQ-024 IDLE: s_axis_tvalid with dst==0 -> beat consumed (tready=1), pkt_drop=1 next cycle, go DROP unless tlast.
REQ-025 FWD/DROP: slave handshake with tlast -> IDLE; mask cleared.
REQ-026 dst bits in tuser of non-first beats SHALL be ignored.
REQ-027 Slowest destination SHALL gate progress; a beat SHALL never be delivered twice to one port nor skipped.
REQ-028 No beat SHALL be consumed from slave while s_axis_tvalid=0; sent[] SHALL hold while tvalid drops is prohibited by AXI and not handled.

Reset
REQ-029 While axis_reset=1: state=IDLE, mask=0, sent=0, pkt_fwd=0, pkt_drop=0, s_axis_tready=0, all m_axis_N_tvalid=0.
REQ-030 Reset mid-packet SHALL abandon the packet; the next slave beat after reset SHALL be treated as a first beat.

Verification
REQ-031 Unicast: 3-beat packet, dst=6'b000100, all ready=1 -> beats on port 2 only, 3 consecutive cycles, pkt_fwd pulses once.
REQ-032 Multicast skew: dst=6'b100001, port 0 ready, port 5 ready 2 cycles late -> port 0 tvalid drops after accept, s_axis_tready high only on cycle port 5 accepts; each port receives each beat exactly once.
REQ-033 Drop: 4-beat packet dst=0 -> s_axis_tready=1 for 4 cycles, no master tvalid, pkt_drop pulses once, pkt_fwd=0.
REQ-034 Back-to-back: 1-beat dst=6'b000010 then 2-beat dst=6'b010000, no gaps -> port 1 then port 4, no idle cycle, two pkt_fwd pulses.
REQ-035 Reset mid-packet: assert axis_reset on beat 2 of 5 -> all outputs zero next cycle; post-reset beat routed by its own tuser dst.
REQ-036 Backpressure hold: dst=6'b001000, m_axis_3_tready=0 for 10 cycles -> m_axis_3_tvalid stays 1, payload stable, s_axis_tready=0.
